// File: rtl/go_board_pkg.sv
// Go Board shared constants: board clock and push-button debounce timing.
// Imported by the switch debounce blocks to derive their default qualification time.
package go_board_pkg;

    localparam int CLK_HZ          = 25_000_000;
    localparam int NUM_SWITCHES    = 4;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: optional 2-flop synchronizer, stability counter,
// clean level and one-cycle press / lift strobes.
// Ports: clk, reset (sync, active-high), raw (bouncing input),
//        level (debounced), press (0->1 strobe), lift (1->0 strobe).
// Macro SWITCH_DEBOUNCE_SYNC_EN: when defined, raw is synchronized first (+2 cycles).
module debounce_channel
    import go_board_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic lift
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sample;
    logic [CNT_WIDTH-1:0] cnt;

`ifdef SWITCH_DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = raw;
`endif

    // Any sample matching the current clean level restarts qualification,
    // so only an unbroken run of DEBOUNCE_LIMIT differing samples commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            lift  <= 1'b0;
        end else begin
            press <= 1'b0;
            lift  <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sample;
                press <= sample;
                lift  <= ~sample;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Go Board push-button front end: per-switch debounce plus press/release strobes.
// Ports: i_Clk, i_Reset (sync, active-high), i_Switch (raw levels),
//        o_Switch (debounced), o_Press (0->1 strobe), o_Release (1->0 strobe).
// Macro SWITCH_DEBOUNCE_SYNC_EN: adds a 2-flop synchronizer per channel.
module switch_debounce #(
    parameter int NUM_SWITCHES   = go_board_pkg::NUM_SWITCHES,
    parameter int DEBOUNCE_LIMIT = go_board_pkg::DEBOUNCE_CYCLES
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Press,
    output logic [NUM_SWITCHES-1:0] o_Release
);

    for (genvar n = 0; n < NUM_SWITCHES; n++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_ch (
            .clk  (i_Clk),
            .reset(i_Reset),
            .raw  (i_Switch[n]),
            .level(o_Switch[n]),
            .press(o_Press[n]),
            .lift (o_Release[n])
        );
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce (DEBOUNCE_LIMIT=4): directed scenarios
// plus randomized bouncing, checked against a sample-history reference model.
module tb_switch_debounce;

    localparam int N   = 4;
    localparam int LIM = 4;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw;
    logic [N-1:0] osw;
    logic [N-1:0] opr;
    logic [N-1:0] orl;

    exp_t         q[$];
    int           errors = 0;
    int           checks = 0;
    bit           done   = 0;

    // Reference model: every sample since reset, and per channel the index
    // of the first sample after its last accepted change.
    logic [N-1:0] samples[$];
    int           since[N];
    logic [N-1:0] m_lvl = '0;
    logic [N-1:0] m_p1  = '0;
    logic [N-1:0] m_p2  = '0;

    switch_debounce #(
        .NUM_SWITCHES  (N),
        .DEBOUNCE_LIMIT(LIM)
    ) dut (
        .i_Clk    (clk),
        .i_Reset  (rst),
        .i_Switch (sw),
        .o_Switch (osw),
        .o_Press  (opr),
        .o_Release(orl)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [N-1:0] v);
        exp_t         e;
        logic [N-1:0] s;
        int           k;
        bit           all_diff;
        rst  = r;
        sw   = v;
        e.pr = '0;
        e.rl = '0;
        if (r) begin
            samples.delete();
            for (int c = 0; c < N; c++) since[c] = 0;
            m_lvl = '0;
            m_p1  = '0;
            m_p2  = '0;
        end else begin
`ifdef SWITCH_DEBOUNCE_SYNC_EN
            s    = m_p2;
            m_p2 = m_p1;
            m_p1 = v;
`else
            s = v;
`endif
            samples.push_back(s);
            k = samples.size();
            for (int c = 0; c < N; c++) begin
                if (k - since[c] >= LIM) begin
                    all_diff = 1;
                    for (int j = k - LIM; j < k; j++)
                        if (samples[j][c] == m_lvl[c]) all_diff = 0;
                    if (all_diff) begin
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) e.pr[c] = 1'b1;
                        else          e.rl[c] = 1'b1;
                        since[c] = k;
                    end
                end
            end
        end
        e.lvl = m_lvl;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(1'b0, v);
    endtask

    // Monitor: one expected record per clock edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL underflow t=%0t: no expected record", $time);
            end else begin
                e = q.pop_front();
                if ({osw, opr, orl} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got lvl=%b press=%b rel=%b, expected lvl=%b press=%b rel=%b",
                             $time, osw, opr, orl, e.lvl, e.pr, e.rl);
                end
            end
            checks++;
            if ((opr & orl) !== '0) begin
                errors++;
                $display("FAIL overlap t=%0t: press=%b rel=%b, required no common bit",
                         $time, opr, orl);
            end
        end
    end

    initial begin : stim
        logic [N-1:0] tgt;
        logic [N-1:0] v;
        logic [7:0]   bounce;
        // 1: switches held through reset, re-qualified afterwards
        repeat (3) step(1'b1, 4'hF);
        hold(4'hF, 6);
        step(1'b1, 4'h0);
        hold(4'h0, 3);
        // 2: channel 0 press
        hold(4'b0001, 6);
        // 3: channel 1 bounces
        bounce = 8'b1111_0111;
        for (int i = 0; i < 8; i++) step(1'b0, {2'b00, bounce[i], 1'b1});
        hold(4'b0011, 3);
        // 4: channel 2 press then release
        hold(4'b0111, 6);
        hold(4'b0011, 6);
        // 5: partial count discarded by reset
        hold(4'b0000, 6);
        hold(4'b1000, 3);
        step(1'b1, 4'b1000);
        hold(4'b1000, 6);
        // 6: all channels together
        hold(4'h0, 6);
        hold(4'hF, 6);
        hold(4'h0, 6);
        // random bouncing with occasional reset
        tgt = '0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 9) == 0) tgt[c] = ~tgt[c];
                v[c] = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : tgt[c];
            end
            step($urandom_range(0, 149) == 0, v);
        end
        done = 1;
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
